aes_axil_regs: RTL and testbench
================================

// Module: aes_axil_regs
// PURPOSE
// AXI4-Lite slave register front end of the simple_aes IP: sits between the bus master (PS / AXI VIP
// master) and the AES core. Holds 128-bit key and plaintext, issues a one-cycle start pulse to the
// core, captures the core's 128-bit result on done, exposes busy/done/error status to software.
// PARAMETERS
// C_S_AXI_DATA_WIDTH  32  AXI4-Lite data width (only 32 supported)
// C_S_AXI_ADDR_WIDTH  6   byte address width; decode uses addr[5:2]
// PORTS
// ACLK           in   1    clock; all logic on rising edge
// ARESETN        in   1    asynchronous active-low reset
// S_AXI_AWADDR   in   6    write address      | S_AXI_AWVALID in 1 | S_AXI_AWREADY out 1
// S_AXI_WDATA    in   32   write data         | S_AXI_WSTRB in 4 byte enables | S_AXI_WVALID in 1 | S_AXI_WREADY out 1
// S_AXI_BRESP    out  2    always 2'b00 OKAY  | S_AXI_BVALID out 1 | S_AXI_BREADY in 1
// S_AXI_ARADDR   in   6    read address       | S_AXI_ARVALID in 1 | S_AXI_ARREADY out 1
// S_AXI_RDATA    out  32   read data          | S_AXI_RRESP out 2 (always OKAY) | S_AXI_RVALID out 1 | S_AXI_RREADY in 1
// key_o          out  128  key register to core; key_o[127:96] = KEY0
// data_o         out  128  plaintext register to core; data_o[127:96] = DIN0
// start_o        out  1    one-cycle start pulse to core
// done_i         in   1    one-cycle pulse from core: result_i valid this cycle
// result_i       in   128  core ciphertext; result_i[127:96] -> DOUT0
// BEHAVIOUR
// - Map (addr[5:2]): 0 CTRL (W: bit0 start, bit2 write-1-clears err; R: 0); 1 STATUS (RO: bit0 busy,
//   bit1 done, bit2 err); 4-7 KEY0-3 RW; 8-11 DIN0-3 RW; 12-15 DOUT0-3 RO; 2,3 unmapped.
// - Reset: all ready/valid outputs 0, RDATA 0, key/data/DOUT 0, busy/done/err 0, start_o 0.
// - Write FSM W_IDLE/W_RESP. In W_IDLE AWREADY=1 until AW captured, WREADY=1 until W captured; AW and W
//   accepted independently, any order or same cycle. Commit in cycle both are held: update register
//   per WSTRB byte, go W_RESP with BVALID=1; hold BVALID until BREADY, then W_IDLE, both readys back to 1.
//   Min latency: AW+W same cycle at edge N -> BVALID high after edge N+1.
// - Read FSM R_IDLE/R_DATA. ARREADY=1 in R_IDLE; on ARVALID capture addr, RDATA/RVALID valid next
//   cycle; hold RDATA stable until RREADY, then R_IDLE. Unmapped/CTRL reads return 0.
// - Writes to STATUS, DOUT, unmapped addresses: ignored, still BRESP OKAY (no SLVERR ever).
// - Start: CTRL write with WSTRB[0]=1, WDATA[0]=1 while busy=0 -> start_o=1 the cycle after commit,
//   busy<=1, done<=0. Same write while busy=1 -> no pulse, err<=1 (sticky). Bit2=1 clears err; if
//   start-rejected and clear in same write, err ends 1.
// - KEY/DIN writes while busy are accepted (core samples on start_o only).
// - done_i while busy=1: DOUT<=result_i, busy<=0, done<=1. done_i while busy=0: ignored.
// - done_i same cycle as a start commit: busy still 1 that cycle -> start rejected, err set, result kept.
// - Read of STATUS same cycle as done_i returns pre-update value.
// - ARESETN low mid-transaction: FSMs to idle, all registers cleared, pending B/R dropped.
// STRUCTURE
// - Package aes_axil_pkg: register index enum (REG_CTRL...REG_DOUT3), STATUS/CTRL bit-position
//   constants, resp_t OKAY, wr_state_t / rd_state_t enums.
// - Single module, no sub-module; KEY/DIN/DOUT as 4x32 arrays concatenated to 128-bit ports.
// TESTING
// - Reset: hold ARESETN low 200 ns -> all AXI valid/ready outputs 0 except AW/W/ARREADY=1 after release; all reads 0.
// - Key/DIN: write 0x00010203,0x04050607,0x08090a0b,0x0c0d0e0f to KEY0-3 and 0x00112233...ccddeeff to
//   DIN0-3 -> readback matches; key_o=128'h000102..0f, data_o=128'h00112233..ccddeeff.
// - Encrypt: write CTRL=1 -> start_o single pulse, STATUS=1; model core drives done_i 10 cycles later
//   with 128'h69c4e0d86a7b0430d8cdb78070b4c55a -> STATUS=2, DOUT0-3 read 69c4e0d8,6a7b0430,d8cdb780,70b4c55a.
// - Busy reject: CTRL=1 twice back-to-back -> one start_o, STATUS=5; CTRL=4 -> STATUS err cleared.
// - Handshake: W before AW by 3 cycles, BREADY low 5 cycles, RREADY low 4 cycles -> BVALID/RVALID/RDATA held stable, one commit only.
// - WSTRB=4'b0010 write 0xAABBCCDD to KEY1 from 0 -> reads 0x0000CC00; write DOUT0/unmapped -> OKAY, no change.

Source files
------------

// File: rtl/aes_axil_pkg.sv
// aes_axil_pkg: register map, status/control bit positions, response and FSM types
package aes_axil_pkg;
  typedef enum logic [3:0] {
    REG_CTRL   = 4'd0,
    REG_STATUS = 4'd1,
    REG_KEY0   = 4'd4,
    REG_KEY1   = 4'd5,
    REG_KEY2   = 4'd6,
    REG_KEY3   = 4'd7,
    REG_DIN0   = 4'd8,
    REG_DIN1   = 4'd9,
    REG_DIN2   = 4'd10,
    REG_DIN3   = 4'd11,
    REG_DOUT0  = 4'd12,
    REG_DOUT1  = 4'd13,
    REG_DOUT2  = 4'd14,
    REG_DOUT3  = 4'd15
  } reg_idx_t;
  localparam logic [1:0] GRP_KEY = 2'd1;
  localparam logic [1:0] GRP_DIN = 2'd2;
  localparam logic [1:0] GRP_DOUT = 2'd3;
  localparam int CTRL_START = 0;
  localparam int CTRL_ERR_CLR = 2;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR = 2;
  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY = 2'b00;
  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = s[i] ? d[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/aes_axil_regs.sv
// aes_axil_regs: AXI4-Lite register front end holding key/plaintext, starting the AES core and capturing its result
module aes_axil_regs
  import aes_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [127:0]                    key_o,
  output logic [127:0]                    data_o,
  output logic                            start_o,
  input  logic                            done_i,
  input  logic [127:0]                    result_i
);
  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  logic init_q, aw_held, w_held, commit, b_done, start_req, clr_req, fin;
  logic busy, done, err;
  logic [3:0] aw_idx, ar_idx, wstrb_q;
  logic [31:0] wdata_q, status, rd_val;
  logic [31:0] key_r [4];
  logic [31:0] din_r [4];
  logic [31:0] dout_r [4];
  logic unused;
  assign unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign key_o = {key_r[0], key_r[1], key_r[2], key_r[3]};
  assign data_o = {din_r[0], din_r[1], din_r[2], din_r[3]};
  assign commit = wr_state == W_IDLE && aw_held && w_held;
  assign b_done = S_AXI_BVALID && S_AXI_BREADY;
  assign S_AXI_AWREADY = init_q && wr_state == W_IDLE && !aw_held;
  assign S_AXI_WREADY = init_q && wr_state == W_IDLE && !w_held;
  assign S_AXI_BVALID = wr_state == W_RESP;
  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_ARREADY = init_q && rd_state == R_IDLE;
  assign S_AXI_RVALID = rd_state == R_DATA;
  assign S_AXI_RRESP = RESP_OKAY;
  assign start_req = commit && aw_idx == REG_CTRL && wstrb_q[0] && wdata_q[CTRL_START];
  assign clr_req = commit && aw_idx == REG_CTRL && wstrb_q[0] && wdata_q[CTRL_ERR_CLR];
  assign fin = busy && done_i;
  assign ar_idx = S_AXI_ARADDR[5:2];
  // Readys stay low while in reset and rise one cycle after release
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) init_q <= 1'b0;
    else init_q <= 1'b1;
  // Write FSM state register
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) wr_state <= W_IDLE;
    else wr_state <= wr_next;
  // Write FSM next state: respond once both halves are held, release on BREADY
  always_comb begin
    wr_next = commit ? W_RESP : b_done ? W_IDLE : wr_state;
  end
  // Capture AW and W independently; both are released when the response is taken
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_idx <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (b_done) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        aw_held <= 1'b1;
        aw_idx <= S_AXI_AWADDR[5:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        w_held <= 1'b1;
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  // KEY/DIN byte-enabled updates on commit; other targets are ignored
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      key_r <= '{default: '0};
      din_r <= '{default: '0};
    end else if (commit && aw_idx[3:2] == GRP_KEY) key_r[aw_idx[1:0]] <= apply_strb(key_r[aw_idx[1:0]], wdata_q, wstrb_q);
    else if (commit && aw_idx[3:2] == GRP_DIN) din_r[aw_idx[1:0]] <= apply_strb(din_r[aw_idx[1:0]], wdata_q, wstrb_q);
  // Core control: start only when idle, a start while busy sets sticky err, done captures the result
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) begin
      start_o <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      dout_r <= '{default: '0};
    end else begin
      start_o <= start_req && !busy;
      busy <= fin ? 1'b0 : start_req ? 1'b1 : busy;
      done <= fin ? 1'b1 : (start_req && !busy) ? 1'b0 : done;
      err <= (start_req && busy) ? 1'b1 : clr_req ? 1'b0 : err;
      if (fin) dout_r <= '{result_i[127:96], result_i[95:64], result_i[63:32], result_i[31:0]};
    end
  // Status word and read mux; CTRL and unmapped read as zero
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done;
    status[ST_ERR] = err;
    rd_val = ar_idx[3:2] == GRP_KEY ? key_r[ar_idx[1:0]] :
             ar_idx[3:2] == GRP_DIN ? din_r[ar_idx[1:0]] :
             ar_idx[3:2] == GRP_DOUT ? dout_r[ar_idx[1:0]] :
             ar_idx == REG_STATUS ? status : '0;
  end
  // Read FSM state register
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) rd_state <= R_IDLE;
    else rd_state <= rd_next;
  // Read FSM next state: data phase after the address handshake, back to idle on RREADY
  always_comb begin
    rd_next = (S_AXI_ARVALID && S_AXI_ARREADY) ? R_DATA : (S_AXI_RVALID && S_AXI_RREADY) ? R_IDLE : rd_state;
  end
  // Read data sampled at the address handshake and held through the data phase
  always_ff @(posedge ACLK or negedge ARESETN)
    if (!ARESETN) S_AXI_RDATA <= '0;
    else if (S_AXI_ARVALID && S_AXI_ARREADY) S_AXI_RDATA <= rd_val;
endmodule

// File: tb/tb_aes_axil_regs.sv
// tb_aes_axil_regs: directed and randomized AXI4-Lite traffic checked against a register-level model
module tb_aes_axil_regs;
  logic ACLK = 1'b0;
  logic ARESETN;
  logic [5:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BREADY;
  logic S_AXI_ARVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0] S_AXI_WSTRB;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic [127:0] key_o, data_o, result_i;
  logic start_o, done_i;
  int checks = 0, errors = 0, start_cnt = 0, exp_starts = 0, b_cnt = 0;
  logic [31:0] m_key [4];
  logic [31:0] m_din [4];
  logic [31:0] m_dout [4];
  logic m_busy, m_done, m_err;

  aes_axil_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .key_o(key_o), .data_o(data_o), .start_o(start_o), .done_i(done_i), .result_i(result_i)
  );

  always #5 ACLK = ~ACLK;
  // Count cycles with start_o high and completed write responses
  always @(posedge ACLK) begin
    if (start_o === 1'b1) start_cnt++;
    if (S_AXI_BVALID === 1'b1 && S_AXI_BREADY === 1'b1) b_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] m_rd(input int idx);
    if (idx == 1) return {29'd0, m_err, m_done, m_busy};
    if (idx >= 4 && idx < 8) return m_key[idx-4];
    if (idx >= 8 && idx < 12) return m_din[idx-8];
    if (idx >= 12) return m_dout[idx-12];
    return 32'd0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_key[i] = 0;
      m_din[i] = 0;
      m_dout[i] = 0;
    end
    m_busy = 0;
    m_done = 0;
    m_err = 0;
  endtask

  task automatic m_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic st, clr, rej;
    if (idx == 0) begin
      st = s[0] && d[0];
      clr = s[0] && d[2];
      rej = st && m_busy;
      if (st && !m_busy) begin
        m_busy = 1;
        m_done = 0;
        exp_starts++;
      end
      if (rej) m_err = 1;
      else if (clr) m_err = 0;
    end else if (idx >= 4 && idx < 8) m_key[idx-4] = merge(m_key[idx-4], d, s);
    else if (idx >= 8 && idx < 12) m_din[idx-8] = merge(m_din[idx-8], d, s);
  endtask

  task automatic m_fin(input logic [127:0] r);
    if (m_busy) begin
      m_dout[0] = r[127:96];
      m_dout[1] = r[95:64];
      m_dout[2] = r[63:32];
      m_dout[3] = r[31:0];
      m_busy = 0;
      m_done = 1;
    end
  endtask

  task automatic pulse_done(input logic [127:0] r);
    result_i = r;
    done_i = 1;
    step();
    done_i = 0;
    m_fin(r);
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
    int n;
    fork
      begin
        bit r;
        int k;
        k = 0;
        repeat (aw_dly) step();
        S_AXI_AWADDR = a;
        S_AXI_AWVALID = 1;
        do begin
          r = S_AXI_AWREADY;
          step();
          k++;
        end while (!r && k < 50);
        S_AXI_AWVALID = 0;
        if (!r) check("aw_timeout", 0, 1);
      end
      begin
        bit r;
        int k;
        k = 0;
        repeat (w_dly) step();
        S_AXI_WDATA = d;
        S_AXI_WSTRB = s;
        S_AXI_WVALID = 1;
        do begin
          r = S_AXI_WREADY;
          step();
          k++;
        end while (!r && k < 50);
        S_AXI_WVALID = 0;
        if (!r) check("w_timeout", 0, 1);
      end
    join
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin
      step();
      n++;
    end
    check($sformatf("bvalid@%0h", a), S_AXI_BVALID, 1);
    check($sformatf("bresp@%0h", a), S_AXI_BRESP, 0);
    for (int i = 0; i < b_dly; i++) begin
      step();
      check("bvalid_hold", S_AXI_BVALID, 1);
    end
    S_AXI_BREADY = 1;
    step();
    S_AXI_BREADY = 0;
    m_write(int'(a[5:2]), d, s);
  endtask

  task automatic axi_read(input logic [5:0] a, input int rr_dly, output logic [31:0] d);
    bit r;
    int k;
    k = 0;
    S_AXI_ARADDR = a;
    S_AXI_ARVALID = 1;
    do begin
      r = S_AXI_ARREADY;
      step();
      k++;
    end while (!r && k < 50);
    S_AXI_ARVALID = 0;
    if (!r) check("ar_timeout", 0, 1);
    k = 0;
    while (!S_AXI_RVALID && k < 50) begin
      step();
      k++;
    end
    check($sformatf("rvalid@%0h", a), S_AXI_RVALID, 1);
    d = S_AXI_RDATA;
    for (int i = 0; i < rr_dly; i++) begin
      step();
      check("rdata_hold", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, d});
    end
    S_AXI_RREADY = 1;
    step();
    S_AXI_RREADY = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input int rr_dly);
    logic [31:0] d;
    axi_read(a, rr_dly, d);
    check(tag, d, m_rd(int'(a[5:2])));
  endtask

  initial begin
    logic [31:0] d, rd;
    logic [127:0] r;
    logic [31:0] kv [4];
    logic [31:0] dv [4];
    int idx, b0;
    logic [3:0] s;
    kv = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    dv = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    ARESETN = 0;
    S_AXI_AWADDR = 0; S_AXI_AWVALID = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0;
    S_AXI_BREADY = 0; S_AXI_ARADDR = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    done_i = 0; result_i = 0;
    m_reset();
    #190;
    check("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 0);
    check("rst_valid", {S_AXI_BVALID, S_AXI_RVALID, start_o}, 0);
    check("rst_regs", {key_o, data_o, S_AXI_RDATA}, 0);
    #10 ARESETN = 1;
    step();
    step();
    check("post_rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID}, 5'b11100);
    for (int i = 0; i < 16; i++) rd_chk($sformatf("rst_rd%0d", i), 6'(i*4), 0);
    for (int i = 0; i < 4; i++) axi_write(6'(16+4*i), kv[i], 4'hf, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_write(6'(32+4*i), dv[i], 4'hf, 0, 0, 0);
    for (int i = 4; i < 12; i++) rd_chk($sformatf("kd_rd%0d", i), 6'(i*4), 0);
    check("key_o", key_o, 128'h000102030405060708090a0b0c0d0e0f);
    check("data_o", data_o, 128'h00112233445566778899aabbccddeeff);
    axi_write(6'h00, 32'h1, 4'h1, 0, 0, 0);
    check("start_single", start_cnt, 1);
    axi_read(6'h04, 0, rd);
    check("status_busy", rd, 1);
    repeat (10) step();
    pulse_done(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    axi_read(6'h04, 0, rd);
    check("status_done", rd, 2);
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(48+4*i), 0, rd);
      check($sformatf("dout%0d", i), rd, m_rd(12+i));
    end
    axi_read(6'h30, 0, rd);
    check("dout0_const", rd, 32'h69c4e0d8);
    axi_write(6'h00, 32'h1, 4'h1, 0, 0, 0);
    axi_write(6'h00, 32'h1, 4'h1, 0, 0, 0);
    check("reject_starts", start_cnt, exp_starts);
    axi_read(6'h04, 0, rd);
    check("status_err", rd, 5);
    axi_write(6'h00, 32'h4, 4'h1, 0, 0, 0);
    axi_read(6'h04, 0, rd);
    check("status_clr", rd, 1);
    pulse_done({$urandom, $urandom, $urandom, $urandom});
    rd_chk("status_after_fin", 6'h04, 0);
    r = {$urandom, $urandom, $urandom, $urandom};
    pulse_done(r);
    rd_chk("idle_done_ignored", 6'h34, 0);
    axi_write(6'h00, 32'h1, 4'h1, 0, 0, 0);
    S_AXI_AWADDR = 6'h00; S_AXI_AWVALID = 1; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'h1; S_AXI_WVALID = 1;
    check("coll_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    step();
    S_AXI_AWVALID = 0;
    S_AXI_WVALID = 0;
    r = {$urandom, $urandom, $urandom, $urandom};
    result_i = r;
    done_i = 1;
    step();
    done_i = 0;
    check("coll_bvalid", S_AXI_BVALID, 1);
    S_AXI_BREADY = 1;
    step();
    S_AXI_BREADY = 0;
    m_write(0, 32'h1, 4'h1);
    m_fin(r);
    check("coll_starts", start_cnt, exp_starts);
    axi_read(6'h04, 0, rd);
    check("coll_status", rd, 6);
    rd_chk("coll_dout3", 6'h3c, 0);
    axi_write(6'h00, 32'h5, 4'h1, 0, 0, 0);
    axi_read(6'h04, 0, rd);
    check("start_clr_status", rd, 1);
    S_AXI_ARADDR = 6'h04;
    S_AXI_ARVALID = 1;
    check("rd_done_arready", S_AXI_ARREADY, 1);
    r = {$urandom, $urandom, $urandom, $urandom};
    result_i = r;
    done_i = 1;
    step();
    S_AXI_ARVALID = 0;
    done_i = 0;
    check("rd_done_pre", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, m_rd(1)});
    S_AXI_RREADY = 1;
    step();
    S_AXI_RREADY = 0;
    m_fin(r);
    rd_chk("rd_done_post", 6'h04, 0);
    b0 = b_cnt;
    axi_write(6'h18, 32'hdeadbeef, 4'hf, 3, 0, 5);
    check("hs_one_commit", b_cnt, b0 + 1);
    rd_chk("hs_key2", 6'h18, 4);
    axi_write(6'h14, 32'h0, 4'hf, 0, 0, 0);
    axi_write(6'h14, 32'haabbccdd, 4'b0010, 0, 0, 0);
    axi_read(6'h14, 0, rd);
    check("strb_key1", rd, 32'h0000cc00);
    axi_write(6'h30, 32'hffffffff, 4'hf, 0, 1, 0);
    axi_write(6'h08, 32'hffffffff, 4'hf, 1, 0, 0);
    axi_write(6'h0c, 32'hffffffff, 4'hf, 0, 0, 0);
    axi_write(6'h04, 32'hffffffff, 4'hf, 0, 0, 0);
    rd_chk("dout0_ro", 6'h30, 0);
    rd_chk("unmapped_rd", 6'h08, 0);
    rd_chk("status_ro", 6'h04, 0);
    rd_chk("ctrl_rd", 6'h00, 0);
    for (int it = 0; it < 40; it++) begin
      idx = $urandom_range(0, 15);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if (idx == 0) d[0] = 1'b0;
      if ($urandom_range(0, 1) == 1)
        axi_write(6'(idx*4), d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      else rd_chk($sformatf("rand_rd%0d", idx), 6'(idx*4), $urandom_range(0, 2));
    end
    check("rand_key_o", key_o, {m_key[0], m_key[1], m_key[2], m_key[3]});
    check("rand_data_o", data_o, {m_din[0], m_din[1], m_din[2], m_din[3]});
    check("total_starts", start_cnt, exp_starts);
    S_AXI_AWADDR = 6'h10; S_AXI_AWVALID = 1; S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hf; S_AXI_WVALID = 1;
    step();
    S_AXI_AWVALID = 0;
    S_AXI_WVALID = 0;
    step();
    check("mid_bvalid", S_AXI_BVALID, 1);
    ARESETN = 0;
    #1;
    check("mid_rst_drop", {S_AXI_BVALID, S_AXI_AWREADY, key_o, data_o}, 0);
    step();
    ARESETN = 1;
    m_reset();
    step();
    step();
    check("mid_rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID}, 4'b1110);
    rd_chk("mid_rst_key0", 6'h10, 0);
    rd_chk("mid_rst_status", 6'h04, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
